// File: rtl/vector_ram_reader_if.sv
// vector_ram_if: P-lane request/response bus between a vector RAM initiator
// and slave. One handshake (valid && ready) carries P lane addresses; the
// slave answers in order with rvalid and P lanes of rdata.
interface vector_ram_if #(
  parameter int LENGTH      = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4
) ();
  localparam int ADDR_WIDTH = $clog2(LENGTH);

  logic                  valid;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr  [PARALLELISM];
  logic [DATA_WIDTH-1:0] wdata [PARALLELISM];
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata [PARALLELISM];
  logic                  rvalid;

  modport master (
    output valid, write, addr, wdata,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  valid, write, addr, wdata,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/vector_ram_reader.sv
// vector_ram_reader: streams `count` consecutive elements starting at
// `base_addr` out of a vector RAM as PARALLELISM-wide beats with per-lane
// keep and a last flag. Requests are credit-limited so that every response
// has a guaranteed FIFO slot; responses are assumed to return in order.
//
// Optional feature macro: VECTOR_RAM_READER_STRIDE_EN adds a `stride` input
// (latched at start); element k then lives at base + k*stride. Without the
// macro the stride is fixed at 1.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; burst parameters latched on accept
// ISSUE  | issuing beat requests while credits allow
// DRAIN  | all requests issued; waiting for the last beat to be popped
// DONE   | one-cycle completion pulse, then back to IDLE
module vector_ram_reader #(
  parameter  int NUMBER_OF_RAMS = 2,
  parameter  int LENGTH         = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int PARALLELISM    = 4,
  parameter  int FIFO_DEPTH     = 4,
  localparam int ADDR_WIDTH     = $clog2(LENGTH),
  localparam int CNT_WIDTH      = $clog2(LENGTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [CNT_WIDTH-1:0]              count,
`ifdef VECTOR_RAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]             stride,
`endif
  output logic                              busy,
  output logic                              done,
  vector_ram_if.master                      ram,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PARALLELISM*DATA_WIDTH-1:0] out_data,
  output logic [PARALLELISM-1:0]            out_keep,
  output logic                              out_last
);

  // Element indices run up to count + PARALLELISM, so they get headroom.
  localparam int IDX_W   = CNT_WIDTH + $clog2(PARALLELISM) + 1;
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int BEAT_W  = PARALLELISM * DATA_WIDTH;
  localparam int ENTRY_W = BEAT_W + PARALLELISM + 1;

  // NUMBER_OF_RAMS only travels with the bus; it is sanity-checked here.
  if (NUMBER_OF_RAMS < 1 || FIFO_DEPTH < 2) begin : g_param_check
    $error("vector_ram_reader: NUMBER_OF_RAMS must be >= 1 and FIFO_DEPTH >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [IDX_W-1:0]      req_elem_q, req_elem_d;
  logic [IDX_W-1:0]      rsp_elem_q, rsp_elem_d;
  logic [OCC_W-1:0]      outstanding_q, outstanding_d;
  logic [OCC_W-1:0]      fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    mem_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] stride_eff;

`ifdef VECTOR_RAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign stride_eff = stride_q;
`else
  assign stride_eff = ADDR_WIDTH'(1);
`endif

  logic                  accept;
  logic                  credit_ok;
  logic                  req_valid;
  logic                  req_fire;
  logic                  req_last;
  logic                  rsp_push;
  logic                  pop;
  logic                  fifo_nempty;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  head_last;
  logic [BEAT_W-1:0]     push_data;
  logic [PARALLELISM-1:0] push_keep;
  logic                  push_last;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ADDR_WIDTH-1:0] lane_addr [PARALLELISM];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept      = (state_q == S_IDLE) && start;
    // Slots already promised (queued + in flight) must leave room for one more beat.
    credit_ok   = ({1'b0, fifo_count_q} + {1'b0, outstanding_q}) < (OCC_W + 1)'(FIFO_DEPTH);
    req_valid   = (state_q == S_ISSUE) && credit_ok;
    req_fire    = req_valid && ram.ready;
    req_last    = (req_elem_q + IDX_W'(PARALLELISM)) >= IDX_W'(count_q);
    // A response with nothing in flight (e.g. left over from before a reset) is dropped.
    rsp_push    = ram.rvalid && (outstanding_q != '0);
    fifo_nempty = (fifo_count_q != '0);
    head_entry  = mem_q[rd_ptr_q];
    head_last   = head_entry[ENTRY_W-1];
    pop         = fifo_nempty && out_ready;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_fire && req_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and bus outputs; address and FIFO head are zeroed when not valid.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    ram.valid = req_valid;
    ram.write = 1'b0;
    for (int j = 0; j < PARALLELISM; j++) begin
      ram.addr[j]  = req_valid ? lane_addr[j] : '0;
      ram.wdata[j] = '0;
    end
    out_valid = fifo_nempty;
    out_data  = fifo_nempty ? head_entry[BEAT_W-1:0] : '0;
    out_keep  = fifo_nempty ? head_entry[BEAT_W +: PARALLELISM] : '0;
    out_last  = fifo_nempty ? head_last : 1'b0;
  end

  // Lane addresses for the current request beat; wrap falls out of truncation.
  always_comb begin
    for (int j = 0; j < PARALLELISM; j++) begin
      lane_addr[j] = base_q + ADDR_WIDTH'(req_elem_q + IDX_W'(j)) * stride_eff;
    end
  end

  // Burst parameters and request/response element cursors.
  always_comb begin
    base_d     = base_q;
    count_d    = count_q;
    req_elem_d = req_elem_q;
    rsp_elem_d = rsp_elem_q;
`ifdef VECTOR_RAM_READER_STRIDE_EN
    stride_d   = stride_q;
`endif
    if (accept) begin
      base_d     = base_addr;
      count_d    = count;
      req_elem_d = '0;
      rsp_elem_d = '0;
`ifdef VECTOR_RAM_READER_STRIDE_EN
      stride_d   = stride;
`endif
    end else begin
      if (req_fire) begin
        req_elem_d = req_elem_q + IDX_W'(PARALLELISM);
      end
      if (rsp_push) begin
        rsp_elem_d = rsp_elem_q + IDX_W'(PARALLELISM);
      end
    end
  end

  // In-flight request counter; a simultaneous issue and return cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !rsp_push) begin
      outstanding_d = outstanding_q + OCC_W'(1);
    end else if (!req_fire && rsp_push) begin
      outstanding_d = outstanding_q - OCC_W'(1);
    end
  end

  // Response beat: keep/last come from the response-side element cursor.
  always_comb begin
    push_data = '0;
    push_keep = '0;
    for (int j = 0; j < PARALLELISM; j++) begin
      push_data[j*DATA_WIDTH +: DATA_WIDTH] = ram.rdata[j];
      push_keep[j] = (rsp_elem_q + IDX_W'(j)) < IDX_W'(count_q);
    end
    push_last  = (rsp_elem_q + IDX_W'(PARALLELISM)) >= IDX_W'(count_q);
    push_entry = {push_last, push_keep, push_data};
  end

  // Output FIFO: occupancy counter decides full/empty; credits prevent overflow.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (rsp_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({rsp_push, pop})
      2'b10:   fifo_count_d = fifo_count_q + OCC_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - OCC_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Datapath registers; reset clears credits and the FIFO mid-burst too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q        <= '0;
      count_q       <= '0;
      req_elem_q    <= '0;
      rsp_elem_q    <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef VECTOR_RAM_READER_STRIDE_EN
      stride_q      <= '0;
`endif
    end else begin
      base_q        <= base_d;
      count_q       <= count_d;
      req_elem_q    <= req_elem_d;
      rsp_elem_q    <= rsp_elem_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
`ifdef VECTOR_RAM_READER_STRIDE_EN
      stride_q      <= stride_d;
`endif
    end
  end

endmodule

// File: tb/tb_vector_ram_reader.sv
// Directed bench for vector_ram_reader with a one-cycle-latency RAM model
// holding RAM[i] = i.
module tb_vector_ram_reader;
  localparam int NUMBER_OF_RAMS = 2;
  localparam int LENGTH         = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int PARALLELISM    = 4;
  localparam int FIFO_DEPTH     = 4;
  localparam int ADDR_WIDTH     = $clog2(LENGTH);
  localparam int CNT_WIDTH      = $clog2(LENGTH + 1);
  localparam int BW             = PARALLELISM * DATA_WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  count;
`ifdef VECTOR_RAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride;
`endif
  logic                  busy;
  logic                  done;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW-1:0]         out_data;
  logic [PARALLELISM-1:0] out_keep;
  logic                  out_last;

  logic                  slv_ready;
  logic                  slv_rvalid;
  logic                  inj_rvalid;
  logic [DATA_WIDTH-1:0] slv_rdata [PARALLELISM];

  int n_cmp;
  int n_bad;
  int req_cnt;
  int done_cnt;
  logic [BW-1:0]          beat_data_q [$];
  logic [PARALLELISM-1:0] beat_keep_q [$];
  logic                   beat_last_q [$];
  int                     req_addr_q  [$];

  vector_ram_if #(.LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH), .PARALLELISM(PARALLELISM)) ram_bus ();

  vector_ram_reader #(
    .NUMBER_OF_RAMS(NUMBER_OF_RAMS), .LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH),
    .PARALLELISM(PARALLELISM), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
`ifdef VECTOR_RAM_READER_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .ram       (ram_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data = address, answered one cycle after acceptance.
  always @(posedge clk) begin
    slv_rvalid <= ram_bus.valid && ram_bus.ready;
    for (int j = 0; j < PARALLELISM; j++) begin
      slv_rdata[j] <= DATA_WIDTH'(ram_bus.addr[j]);
    end
  end
  assign ram_bus.ready  = slv_ready;
  assign ram_bus.rvalid = slv_rvalid | inj_rvalid;
  for (genvar g = 0; g < PARALLELISM; g++) begin : g_rdata
    assign ram_bus.rdata[g] = slv_rdata[g];
  end

  // Monitor on the falling edge: what will be accepted at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        beat_data_q.push_back(out_data);
        beat_keep_q.push_back(out_keep);
        beat_last_q.push_back(out_last);
      end
      if (ram_bus.valid && ram_bus.ready) begin
        req_cnt++;
        for (int j = 0; j < PARALLELISM; j++) begin
          req_addr_q.push_back(int'(ram_bus.addr[j]));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beat_data_q.delete();
    beat_keep_q.delete();
    beat_last_q.delete();
    req_addr_q.delete();
    req_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic start_burst(input int b, input int c);
    @(posedge clk); #1;
    base_addr = ADDR_WIDTH'(b);
    count     = CNT_WIDTH'(c);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, "_done"}, BW'(done), BW'(1));
    @(posedge clk); #1;
    check_val({tag, "_busy_after"}, BW'(busy), BW'(0));
    check_val({tag, "_done_pulses"}, BW'(done_cnt), BW'(1));
  endtask

  function automatic logic [BW-1:0] beat_of(input int e0, input int e1, input int e2, input int e3);
    logic [BW-1:0] v;
    v = {DATA_WIDTH'(e3), DATA_WIDTH'(e2), DATA_WIDTH'(e1), DATA_WIDTH'(e0)};
    return v;
  endfunction

  task automatic check_beat(input string tag, input int idx, input logic [BW-1:0] exp_d,
                            input logic [PARALLELISM-1:0] exp_k, input logic exp_l);
    logic [BW-1:0] mask;
    if (idx >= beat_data_q.size()) begin
      check_val({tag, "_present"}, BW'(beat_data_q.size()), BW'(idx + 1));
      return;
    end
    mask = '0;
    for (int j = 0; j < PARALLELISM; j++) begin
      if (exp_k[j]) mask[j*DATA_WIDTH +: DATA_WIDTH] = '1;
    end
    check_val({tag, "_data"}, beat_data_q[idx] & mask, exp_d & mask);
    check_val({tag, "_keep"}, BW'(beat_keep_q[idx]), BW'(exp_k));
    check_val({tag, "_last"}, BW'(beat_last_q[idx]), BW'(exp_l));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},      BW'(busy), BW'(0));
    check_val({tag, "_done"},      BW'(done), BW'(0));
    check_val({tag, "_ram_valid"}, BW'(ram_bus.valid), BW'(0));
    check_val({tag, "_ram_write"}, BW'(ram_bus.write), BW'(0));
    check_val({tag, "_ram_addr1"}, BW'(ram_bus.addr[1]), BW'(0));
    check_val({tag, "_out_valid"}, BW'(out_valid), BW'(0));
    check_val({tag, "_out_keep"},  BW'(out_keep), BW'(0));
    check_val({tag, "_out_last"},  BW'(out_last), BW'(0));
    check_val({tag, "_out_data"},  out_data, BW'(0));
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
`ifdef VECTOR_RAM_READER_STRIDE_EN
    stride = ADDR_WIDTH'(1);
`endif
    out_ready  = 1'b1;
    slv_ready  = 1'b1;
    inj_rvalid = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst_n = 1'b1;

    // Aligned two-beat burst, with first-request and first-beat timing.
    clear_mon();
    start_burst(0, 8);
    check_val("t1_busy_rise", BW'(busy), BW'(1));
    check_val("t1_req_valid", BW'(ram_bus.valid), BW'(1));
    check_val("t1_addr3", BW'(ram_bus.addr[3]), BW'(3));
    @(posedge clk); #1;
    check_val("t1_out_valid_early", BW'(out_valid), BW'(0));
    @(posedge clk); #1;
    check_val("t1_out_valid_first", BW'(out_valid), BW'(1));
    wait_done("t1", 50);
    check_val("t1_beats", BW'(beat_data_q.size()), BW'(2));
    check_beat("t1_b0", 0, beat_of(0, 1, 2, 3), 4'hF, 1'b0);
    check_beat("t1_b1", 1, beat_of(4, 5, 6, 7), 4'hF, 1'b1);

    // Address wrap with a partial final beat.
    clear_mon();
    start_burst(30, 6);
    wait_done("t2", 50);
    check_val("t2_beats", BW'(beat_data_q.size()), BW'(2));
    check_beat("t2_b0", 0, beat_of(30, 31, 0, 1), 4'hF, 1'b0);
    check_beat("t2_b1", 1, beat_of(2, 3, 0, 0), 4'b0011, 1'b1);
    check_val("t2_masked_addr", BW'(req_addr_q.size() > 7 ? req_addr_q[7] : -1), BW'(5));

    // Back-pressure: credits stop requests once the FIFO is spoken for.
    clear_mon();
    out_ready = 1'b0;
    start_burst(0, 32);
    repeat (20) @(posedge clk);
    #1;
    check_val("t3_req_stalled", BW'(req_cnt), BW'(FIFO_DEPTH));
    check_val("t3_ram_valid_low", BW'(ram_bus.valid), BW'(0));
    check_val("t3_head_held_valid", BW'(out_valid), BW'(1));
    check_val("t3_head_held_data", out_data, beat_of(0, 1, 2, 3));
    out_ready = 1'b1;
    wait_done("t3", 200);
    check_val("t3_beats", BW'(beat_data_q.size()), BW'(8));
    for (int b = 0; b < 8; b++) begin
      check_beat($sformatf("t3_b%0d", b), b,
                 beat_of(4*b, 4*b + 1, 4*b + 2, 4*b + 3), 4'hF, (b == 7));
    end

    // Zero-length burst: straight to DONE, nothing on either bus.
    clear_mon();
    start_burst(5, 0);
    check_val("t4_done_now", BW'(done), BW'(1));
    @(posedge clk); #1;
    check_val("t4_done_gone", BW'(done), BW'(0));
    check_val("t4_busy_gone", BW'(busy), BW'(0));
    check_val("t4_reqs", BW'(req_cnt), BW'(0));
    check_val("t4_beats", BW'(beat_data_q.size()), BW'(0));

    // Reset in the middle of a burst, a stray response, then a fresh burst.
    clear_mon();
    out_ready = 1'b0;
    start_burst(0, 32);
    n = 0;
    while (req_cnt < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("t5_two_reqs", BW'(req_cnt >= 2), BW'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    inj_rvalid = 1'b1;
    @(posedge clk); #1;
    inj_rvalid = 1'b0;
    @(posedge clk); #1;
    check_val("t5_stray_ignored", BW'(out_valid), BW'(0));
    clear_mon();
    start_burst(4, 4);
    wait_done("t5", 50);
    check_val("t5_beats", BW'(beat_data_q.size()), BW'(1));
    check_beat("t5_b0", 0, beat_of(4, 5, 6, 7), 4'hF, 1'b1);

`ifdef VECTOR_RAM_READER_STRIDE_EN
    // Strided walk: elements 1, 4, 7, 10.
    clear_mon();
    stride = ADDR_WIDTH'(3);
    start_burst(1, 4);
    wait_done("t6", 50);
    check_beat("t6_b0", 0, beat_of(1, 4, 7, 10), 4'hF, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
